alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//   Shares one combinational ALU (ops ADD/SUB/MUL/OR/AND, 3-bit control) between two requesters,
//   e.g. the execute stage and a multi-cycle helper unit. Round-robin grant, valid/ready request
//   handshake, latched operands, per-requester registered result with one-cycle done pulse.
//   MUL is held on the ALU for MUL_CYCLES cycles to meet timing; other ops take one EXEC cycle.
// PARAMETERS
//   WIDTH       32  operand/result width
//   MUL_CYCLES  3   EXEC cycles for MUL (>=1); all other ops use 1
// PORTS
//   clk_i            in   1      clock, all state on rising edge
//   rst_i            in   1      synchronous, active-high reset
//   reqN_valid_i     in   1      requester N (N=0,1) has an op; hold op/operands stable until ready
//   reqN_op_i        in   3      ALU control: 000 ADD, 001 SUB, 010 MUL, 100 OR, 101 AND
//   reqN_a_i         in   WIDTH  operand 1
//   reqN_b_i         in   WIDTH  operand 2
//   reqN_ready_o     out  1      accept strobe; transfer when valid & ready
//   reqN_result_o    out  WIDTH  registered result, holds until next completion for N
//   reqN_done_o      out  1      one-cycle pulse, reqN_result_o valid this cycle
//   alu_ctrl_o       out  3      to ALU control input
//   alu_data1_o      out  WIDTH  to ALU data1
//   alu_data2_o      out  WIDTH  to ALU data2
//   alu_result_i     in   WIDTH  from ALU result
// BEHAVIOUR
//   Reset: state IDLE, all ready/done 0, results 0, alu_ctrl/data 0, last-grant = 1 (req0 first).
//   FSM: IDLE -> EXEC -> IDLE. No other states.
//   IDLE: if any valid, grant = round-robin (the requester other than last-grant wins a tie; a lone
//     valid requester always wins). reqN_ready_o = 1 combinationally for the grantee only, same
//     cycle. On that edge latch op/a/b, grant id, last-grant <= grant; cnt <= MUL_CYCLES-1 for MUL,
//     else 0; go EXEC. ready_o is 0 in EXEC and for the loser.
//   EXEC: alu_ctrl/data1/data2 driven from latched registers (stable all EXEC cycles). cnt>0: cnt--.
//     cnt==0: grantee result <= alu_result_i (0 for unsupported op 011/110/111), done pulse
//     next cycle, go IDLE.
//   Latency: accept at cycle T -> done at T+2 (non-MUL), T+1+MUL_CYCLES (MUL).
//   Throughput: done pulse cycle is an IDLE cycle; a new accept may occur in it (back-to-back
//     non-MUL ops every 2 cycles).
//   alu_* outputs hold last latched values in IDLE (no toggling when idle).
//   Other requester's result/done unaffected by a completion. done never asserted for both ports
//     in one cycle.
//   Fairness: with both valid continuously, grants strictly alternate 0,1,0,1...
//   Valid dropped before ready: no transfer, no state change. Valid is not required to stay high
//     after accept.
//   rst_i mid-EXEC: operation abandoned, no done pulse, reset values next cycle.
//   Arithmetic: WIDTH-bit wrap-around, MUL returns low WIDTH bits; no flags.
// TESTING
//   Reset, then req0 ADD 5+7 at T -> ready0=1 at T, done0=1 at T+2, result0=12, ready1/done1 stay 0.
//   req1 MUL 0x10000*0x10001, MUL_CYCLES=3 -> alu_ctrl=010 for 3 cycles, done1 at T+4,
//     result1=0x00010000 (wrap).
//   Both valid held high, 4 SUB ops each -> grant order 0,1,0,1,...; accepts every 2 cycles.
//   req0 op=111 a=3 b=4 -> done0 at T+2, result0=0; later req0 OR 0xF0|0x0F -> result0=0xFF.
//   Assert rst_i in 2nd EXEC cycle of a MUL -> no done pulse, all outputs 0 next cycle, then
//     req0 wins first arbitration.
//   req1 result 0xAA held; req0 AND completes -> result1 still 0xAA, done1 stays 0.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Request/response bundle for the two ALU requesters plus the shared-ALU bus.
// Index 0/1 of each packed array selects the requester.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic [1:0]            valid;
  logic [1:0][2:0]       op;
  logic [1:0][WIDTH-1:0] a;
  logic [1:0][WIDTH-1:0] b;
  logic [1:0]            ready;
  logic [1:0][WIDTH-1:0] result;
  logic [1:0]            done;
  logic [2:0]            alu_ctrl;
  logic [WIDTH-1:0]      alu_data1;
  logic [WIDTH-1:0]      alu_data2;
  logic [WIDTH-1:0]      alu_result;

  modport slave (
    input  valid, op, a, b, alu_result,
    output ready, result, done, alu_ctrl, alu_data1, alu_data2
  );

  modport master (
    output valid, op, a, b, alu_result,
    input  ready, result, done, alu_ctrl, alu_data1, alu_data2
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// MUL occupies the ALU for MUL_CYCLES EXEC cycles, everything else for one.

// Per-requester result register and one-cycle done pulse.
module alu_arbiter_port #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             fin,
  input  logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] result,
  output logic             done
);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= fin;
      if (fin) result <= res;
    end
  end
endmodule

module alu_arbiter #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  alu_arbiter_if.slave bus
);
  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [2:0] OP_MUL = 3'b010;

  typedef enum logic { IDLE, EXEC } state_t;

  state_t           state, state_nxt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             gnt_q, gnt_nxt, last_q;
  logic [CW-1:0]    cnt_q;
  logic [1:0]       ready;
  logic             accept, finish, op_ok;
  logic [WIDTH-1:0] res;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = last_q;
    ready     = '0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.valid) begin
          // On a tie the requester that did not win last time goes first.
          gnt_nxt        = (&bus.valid) ? ~last_q : ~bus.valid[0];
          ready[gnt_nxt] = 1'b1;
          accept         = 1'b1;
          state_nxt      = EXEC;
        end
      end
      EXEC: if (cnt_q == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      gnt_q  <= 1'b0;
      last_q <= 1'b1;
      cnt_q  <= '0;
    end else if (accept) begin
      op_q   <= bus.op[gnt_nxt];
      a_q    <= bus.a[gnt_nxt];
      b_q    <= bus.b[gnt_nxt];
      gnt_q  <= gnt_nxt;
      last_q <= gnt_nxt;
      cnt_q  <= (bus.op[gnt_nxt] == OP_MUL) ? CW'(MUL_CYCLES - 1) : '0;
    end else if (state == EXEC && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Codes 011/110/111 have no ALU function; their result is forced to zero.
  always_comb begin
    case (op_q)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: op_ok = 1'b1;
      default:                                op_ok = 1'b0;
    endcase
  end

  assign finish        = (state == EXEC) && (cnt_q == '0);
  assign res           = op_ok ? bus.alu_result : '0;
  assign bus.ready     = ready;
  assign bus.alu_ctrl  = op_q;
  assign bus.alu_data1 = a_q;
  assign bus.alu_data2 = b_q;

  for (genvar i = 0; i < 2; i++) begin : g_port
    alu_arbiter_port #(.WIDTH(WIDTH)) u_port (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .fin    (finish && (gnt_q == 1'(i))),
      .res    (res),
      .result (bus.result[i]),
      .done   (bus.done[i])
    );
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: models the shared ALU, checks handshake,
// latency, arbitration order, unsupported ops and mid-operation reset.
module tb_alu_arbiter;
  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, MUL = 3'b010, OR_ = 3'b100, AND_ = 3'b101;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(32)) bus ();

  alu_arbiter #(.WIDTH(32), .MUL_CYCLES(3)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Shared ALU; garbage on unsupported codes so the arbiter must zero them.
  always_comb begin
    case (bus.alu_ctrl)
      ADD:     bus.alu_result = bus.alu_data1 + bus.alu_data2;
      SUB:     bus.alu_result = bus.alu_data1 - bus.alu_data2;
      MUL:     bus.alu_result = bus.alu_data1 * bus.alu_data2;
      OR_:     bus.alu_result = bus.alu_data1 | bus.alu_data2;
      AND_:    bus.alu_result = bus.alu_data1 & bus.alu_data2;
      default: bus.alu_result = 32'hDEAD_BEEF;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input int n, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.valid[n] = 1'b1;
    bus.op[n]    = op;
    bus.a[n]     = a;
    bus.b[n]     = b;
  endtask

  initial begin
    bus.valid = '0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    rst       = 1'b1;
    repeat (2) tick();
    chk("rst_ready",   32'(bus.ready), 0);
    chk("rst_done",    32'(bus.done), 0);
    chk("rst_result0", bus.result[0], 0);
    chk("rst_result1", bus.result[1], 0);
    chk("rst_ctrl",    32'(bus.alu_ctrl), 0);
    chk("rst_data1",   bus.alu_data1, 0);
    chk("rst_data2",   bus.alu_data2, 0);
    rst = 1'b0;
    tick();

    // ADD 5+7 from req0: ready same cycle, done two cycles later
    req(0, ADD, 5, 7);
    #1 chk("add_ready", 32'(bus.ready), 32'b01);
    tick();
    bus.valid[0] = 1'b0;
    #1 chk("add_exec_ready", 32'(bus.ready), 0);
    chk("add_exec_ctrl",  32'(bus.alu_ctrl), 32'(ADD));
    chk("add_exec_data1", bus.alu_data1, 5);
    chk("add_exec_data2", bus.alu_data2, 7);
    chk("add_exec_done",  32'(bus.done), 0);
    tick();
    chk("add_done",    32'(bus.done), 32'b01);
    chk("add_result0", bus.result[0], 12);
    tick();
    chk("add_done_off", 32'(bus.done), 0);
    chk("add_hold",     bus.result[0], 12);

    // MUL from req1 wraps to the low word, three EXEC cycles
    req(1, MUL, 32'h0001_0000, 32'h0001_0001);
    #1 chk("mul_ready", 32'(bus.ready), 32'b10);
    tick();
    bus.valid[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("mul_exec_ctrl", 32'(bus.alu_ctrl), 32'(MUL));
      chk("mul_exec_done", 32'(bus.done), 0);
      if (i < 2) tick();
    end
    tick();
    chk("mul_done",      32'(bus.done), 32'b10);
    chk("mul_result1",   bus.result[1], 32'h0001_0000);
    chk("mul_result0_k", bus.result[0], 12);
    tick();
    chk("mul_done_off",  32'(bus.done), 0);
    chk("idle_ctrl_hold", 32'(bus.alu_ctrl), 32'(MUL));

    // Both valid held: grants alternate 0,1,0,1 with an accept every 2 cycles
    req(0, SUB, 100, 1);
    req(1, SUB, 200, 2);
    for (int k = 0; k < 8; k++) begin
      int g;
      g = k % 2;
      #1 chk("rr_ready", 32'(bus.ready), (g == 0) ? 32'b01 : 32'b10);
      tick();
      if (k + 2 < 8) req(g, SUB, 32'(100 * (k + 3)), 32'(k + 3));
      else           bus.valid[g] = 1'b0;
      #1 chk("rr_exec_ready", 32'(bus.ready), 0);
      tick();
      chk("rr_done",   32'(bus.done), (g == 0) ? 32'b01 : 32'b10);
      chk("rr_result", bus.result[g], 32'(99 * (k + 1)));
    end

    // Unsupported op yields zero, then OR works normally
    req(0, 3'b111, 3, 4);
    #1 chk("bad_ready", 32'(bus.ready), 32'b01);
    tick();
    bus.valid[0] = 1'b0;
    tick();
    chk("bad_done",    32'(bus.done), 32'b01);
    chk("bad_result0", bus.result[0], 0);
    tick();
    req(0, OR_, 32'hF0, 32'h0F);
    tick();
    bus.valid[0] = 1'b0;
    tick();
    chk("or_done",    32'(bus.done), 32'b01);
    chk("or_result0", bus.result[0], 32'hFF);

    // Reset during the 2nd EXEC cycle of a MUL abandons it
    tick();
    req(0, MUL, 6, 7);
    tick();
    bus.valid[0] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_done",    32'(bus.done), 0);
    chk("mrst_result0", bus.result[0], 0);
    chk("mrst_result1", bus.result[1], 0);
    chk("mrst_ctrl",    32'(bus.alu_ctrl), 0);
    chk("mrst_data1",   bus.alu_data1, 0);

    // After reset req0 wins the first tie; req1 result then survives a req0 completion
    req(0, ADD, 1, 1);
    req(1, OR_, 32'hA0, 32'h0A);
    #1 chk("post_rst_ready", 32'(bus.ready), 32'b01);
    tick();
    bus.valid[0] = 1'b0;
    chk("post_rst_exec_done", 32'(bus.done), 0);
    tick();
    chk("post_rst_done0", 32'(bus.done), 32'b01);
    chk("post_rst_res0",  bus.result[0], 2);
    chk("post_rst_ready1", 32'(bus.ready), 32'b10);
    tick();
    bus.valid[1] = 1'b0;
    tick();
    chk("aa_done1",   32'(bus.done), 32'b10);
    chk("aa_result1", bus.result[1], 32'hAA);
    tick();
    req(0, AND_, 32'hFF, 32'h3C);
    tick();
    bus.valid[0] = 1'b0;
    #1 chk("and_exec_done", 32'(bus.done), 0);
    tick();
    chk("and_done0",    32'(bus.done), 32'b01);
    chk("and_result0",  bus.result[0], 32'h3C);
    chk("and_result1k", bus.result[1], 32'hAA);
    tick();
    chk("and_done_off", 32'(bus.done), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
